magia_print_arbiter: RTL
========================

Name: magia_print_arbiter

Overview:
Shares one character-output sink and one exit-code collector among NumReq requesters (cores/tiles emitting stdio bytes and stderr exit codes).
- Arbitration is round-robin with line locking, so lines from different requesters never interleave.
- Accepted characters are buffered in a FIFO and drained to the bench/host sink.
- Exit codes are collected per requester; end-of-computation is raised once every requester has reported.

Parameters:
NumReq, 4, number of requesters (>=2)
FifoDepth, 8, output FIFO entries (power of 2, >=2)
LockTimeout, 64, idle cycles before a held line lock is released (used only with the optional feature)
ErrW, 16, width of accumulated error sum

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-high
req_valid_i  input  NumReq  per-requester character/exit request valid
req_data_i  input  NumReq*8  per-requester byte
req_is_exit_i  input  NumReq  1 = byte is an exit code, 0 = stdio character
req_ready_o  output  NumReq  per-requester accept
out_valid_o  output  1  FIFO head valid
out_char_o  output  8  FIFO head character
out_src_o  output  $clog2(NumReq)  FIFO head source id
out_ready_i  input  1  sink accepts head
exit_seen_o  output  NumReq  sticky per-requester exit received
err_sum_o  output  ErrW  saturating sum of exit codes
eoc_o  output  1  all requesters reported exit
fifo_level_o  output  $clog2(FifoDepth)+1  FIFO occupancy

Behaviour:
- Reset (rst_n=1, asynchronous): all outputs 0; FIFO empty; RR pointer 0; state IDLE; lock cleared.
- FSM states:
  - IDLE: select the first valid requester at or after the RR pointer; go to LOCKED(g) in the same cycle, and its handshake may complete in that same cycle.
  - LOCKED(g): only g may handshake. Release to IDLE when g's accepted byte is 0x0A (newline) or is an exit code; RR pointer <= g+1 mod NumReq.
- Exit requests bypass the FIFO but still need grant:
  - Handshake when granted, regardless of FIFO full.
  - On handshake: exit_seen_o[g] <= 1; err_sum_o += data, saturating at 2^ErrW-1.
  - Repeat exits from the same requester are still summed.
- Char handshake: req_ready_o[g] = granted & (!fifo_full | (out_valid_o & out_ready_i)). On handshake, push {g, data}.
- FIFO:
  - Pop on out_valid_o & out_ready_i.
  - Push and pop in the same cycle is allowed when full (level unchanged) and when empty-with-push.
  - Zero-latency bypass is not allowed: a byte pushed at cycle N is visible at out_valid_o at N+1.
- req_ready_o is combinational from state/FIFO, never from req_valid_i. A requester must hold valid/data stable until ready.
- Non-granted requesters see ready=0.
- eoc_o = &exit_seen_o, registered (1 cycle after the last exit handshake), sticky until reset.
- Byte 0x00 on a char request is accepted but not pushed; it does not release the lock.
- Reset mid-line: lock, FIFO and sums are discarded; no partial output.

Optional Feature:
MAGIA_PRINT_LOCK_TIMEOUT_EN:
- Defined: a counter in LOCKED increments each cycle without a handshake from g and clears on any g handshake. When it reaches LockTimeout-1, the FSM returns to IDLE next cycle (RR pointer <= g+1), preventing a stalled requester from starving others.
- Undefined: no counter; the lock is held indefinitely until newline or exit.

Decomposition:
- Package magia_print_pkg holds:
  - arb_state_e {IDLE, LOCKED}
  - print_entry_t {src, char}
  - constants NEWLINE=8'h0A and NUL=8'h00
- One sub-module, magia_print_fifo: generic FIFO of print_entry_t, depth FifoDepth, with level output.
- Arbiter FSM, RR pointer and exit accumulator live in the top.

Test Plan:
- Req0 sends "AB\n" while req1 holds 'X' valid -> out sequence A,B,\n (src 0) then X (src 1); req1 ready stays 0 until after \n.
- All 4 requesters valid continuously with single-char lines "k\n" -> grant order 0,1,2,3,0; fifo_level never exceeds 8.
- out_ready_i=0, req0 streams 10 chars without newline -> 8 accepted, ready drops at fifo_level_o=8; one pop with a simultaneous push keeps level at 8.
- Exits 1,2,0,3 from req0..3 -> exit_seen_o=4'hF, err_sum_o=6, eoc_o rises 1 cycle after the last handshake. With ErrW=2, exits 3,3 -> err_sum_o saturates at 3.
- With MAGIA_PRINT_LOCK_TIMEOUT_EN and LockTimeout=4: req0 sends 'A', then idles with req1 valid -> req1 granted exactly after 4 idle cycles. Without the macro, req1 is never granted.
- Assert rst_n mid-line with 3 FIFO entries -> all outputs 0 immediately; after release, the first output is fresh data only.

Source files
------------

// File: rtl/magia_print_pkg.sv
// Shared types and constants for the print/exit-code arbiter.
package magia_print_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  localparam int unsigned SrcW = 8;

  typedef struct packed {
    logic [SrcW-1:0] src;
    logic [7:0]      chr;
  } print_entry_t;

  localparam logic [7:0] NEWLINE = 8'h0A;
  localparam logic [7:0] NUL     = 8'h00;

endpackage

// File: rtl/magia_print_fifo.sv
// Synchronous FIFO of print entries with occupancy output; no write-to-read bypass.
module magia_print_fifo
  import magia_print_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  print_entry_t             wdata_i,
  input  logic                     pop_i,
  output print_entry_t             rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW = $clog2(Depth);

  print_entry_t mem_q [Depth];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  always_comb begin
    level_o = wr_ptr_q - rd_ptr_q;
    valid_o = (level_o != '0);
    full_o  = (level_o == (AW+1)'(Depth));
    do_pop  = pop_i & valid_o;
    // A full FIFO still accepts when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/magia_print_arbiter.sv
// Round-robin, line-locked arbiter sharing one stdio sink and exit collector among requesters.
// Optional macro MAGIA_PRINT_LOCK_TIMEOUT_EN releases a lock held idle for LockTimeout cycles.
module magia_print_arbiter
  import magia_print_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned LockTimeout = 64,
  parameter int unsigned ErrW        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NumReq-1:0]            req_valid_i,
  input  logic [NumReq*8-1:0]          req_data_i,
  input  logic [NumReq-1:0]            req_is_exit_i,
  output logic [NumReq-1:0]            req_ready_o,
  output logic                         out_valid_o,
  output logic [7:0]                   out_char_o,
  output logic [$clog2(NumReq)-1:0]    out_src_o,
  input  logic                         out_ready_i,
  output logic [NumReq-1:0]            exit_seen_o,
  output logic [ErrW-1:0]              err_sum_o,
  output logic                         eoc_o,
  output logic [$clog2(FifoDepth):0]   fifo_level_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned SumW = ((ErrW > 8) ? ErrW : 8) + 1;

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d, rr_q, rr_d;
  logic [IdxW-1:0]   sel_idx, cand, gidx, rr_next;
  logic              sel_any, granted, grant_ok, hs, release_lock, timeout;
  logic              cur_valid, cur_exit;
  logic [7:0]        cur_data;

  logic [NumReq-1:0] exit_seen_q, exit_seen_d;
  logic [ErrW-1:0]   err_sum_q, err_sum_d;
  logic              eoc_q, eoc_d;
  logic [SumW-1:0]   sum_ext;

  print_entry_t      wr_entry, head;
  logic              fifo_push, fifo_pop, fifo_valid, fifo_full;
  logic              unused_src_hi;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumReq);
      if (!sel_any && req_valid_i[cand]) begin
        sel_any = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    gidx         = (state_q == IDLE) ? sel_idx : grant_q;
    granted      = (state_q == IDLE) ? sel_any : 1'b1;
    cur_valid    = req_valid_i[gidx];
    cur_exit     = req_is_exit_i[gidx];
    cur_data     = req_data_i[8*gidx +: 8];
    fifo_pop     = fifo_valid & out_ready_i;
    grant_ok     = granted & (cur_exit | ~fifo_full | fifo_pop) & ~rst_n;
    hs           = grant_ok & cur_valid;
    release_lock = hs & (cur_exit | (cur_data == NEWLINE));
    fifo_push    = hs & ~cur_exit & (cur_data != NUL);
    rr_next      = (gidx == IdxW'(NumReq - 1)) ? '0 : gidx + 1'b1;
    wr_entry.src = SrcW'(gidx);
    wr_entry.chr = cur_data;
  end

`ifdef MAGIA_PRINT_LOCK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(LockTimeout) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    timeout = (state_q == LOCKED) & ~hs & (cnt_q == CntW'(LockTimeout - 1));
    cnt_d   = ((state_q != LOCKED) || hs) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^LockTimeout;
  assign timeout = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          if (release_lock) begin
            rr_d = rr_next;
          end else begin
            state_d = LOCKED;
            grant_d = sel_idx;
          end
        end
      end
      LOCKED: begin
        if (release_lock || timeout) begin
          state_d = IDLE;
          rr_d    = rr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready_o = '0;
    if (grant_ok) req_ready_o[gidx] = 1'b1;
  end

  // Exit collection bypasses the FIFO.
  always_comb begin
    sum_ext     = SumW'(err_sum_q) + SumW'(cur_data);
    err_sum_d   = err_sum_q;
    exit_seen_d = exit_seen_q;
    if (hs && cur_exit) begin
      exit_seen_d[gidx] = 1'b1;
      if (sum_ext > SumW'({ErrW{1'b1}})) err_sum_d = '1;
      else                               err_sum_d = sum_ext[ErrW-1:0];
    end
    eoc_d = eoc_q | (&exit_seen_d);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      exit_seen_q <= '0;
      err_sum_q   <= '0;
      eoc_q       <= 1'b0;
    end else begin
      exit_seen_q <= exit_seen_d;
      err_sum_q   <= err_sum_d;
      eoc_q       <= eoc_d;
    end
  end

  magia_print_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (wr_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

  // Head contents are gated so the sink sees zeros while the FIFO is empty.
  assign out_valid_o   = fifo_valid;
  assign out_char_o    = fifo_valid ? head.chr : 8'h00;
  assign out_src_o     = fifo_valid ? head.src[IdxW-1:0] : '0;
  assign unused_src_hi = ^(head.src >> IdxW);

  assign exit_seen_o = exit_seen_q;
  assign err_sum_o   = err_sum_q;
  assign eoc_o       = eoc_q;

endmodule
